// File: rtl/leg_call_stack_if.sv
// Bundles the execute-stage inputs and CALL/RET outputs of the LEG return-address stack.
// The core side uses the master modport; the stack itself uses the slave modport.
interface leg_call_stack_if #(
    parameter int ADDR_W   = 8,
    parameter int OPCODE_W = 8,
    parameter int DEPTH    = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   pc;
    logic                valid;
    logic                err_clr;

    logic                call;
    logic                ret;
    logic [ADDR_W-1:0]   return_address;
    logic [ADDR_W-1:0]   ret_target;
    logic                redirect;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                underflow;

    modport master (
        output opcode, pc, valid, err_clr,
        input  call, ret, return_address, ret_target, redirect,
               count, full, empty, overflow, underflow
    );

    modport slave (
        input  opcode, pc, valid, err_clr,
        output call, ret, return_address, ret_target, redirect,
               count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/leg_call_stack.sv
// CALL/RET decode and circular return-address stack for the LEG core.
// Define LEG_RSTACK_CIRCULAR_EN to overwrite the oldest entry on CALL while full (default: drop).
module leg_call_stack #(
    parameter int                  ADDR_W      = 8,
    parameter int                  OPCODE_W    = 8,
    parameter int                  DEPTH       = 8,
    parameter logic [OPCODE_W-1:0] CALL_OP     = 8'h26,
    parameter logic [OPCODE_W-1:0] RET_OP      = 8'h27,
    parameter int                  INSTR_BYTES = 4
) (
    input logic             clk,
    input logic             rst,
    leg_call_stack_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  head_inc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_q;
    logic              unf_q;

    logic              is_call;
    logic              is_ret;
    logic              full_w;
    logic              empty_w;
    logic              push;
    logic              pop;
    logic              ovf_evt;
    logic              unf_evt;
    logic [ADDR_W-1:0] ret_addr;

    assign is_call = bus.valid && (bus.opcode == CALL_OP);
    assign is_ret  = bus.valid && (bus.opcode == RET_OP);
    assign full_w  = (cnt == CNT_DEPTH);
    assign empty_w = (cnt == '0);

    // head is the next free slot; the top entry sits one below it, modulo DEPTH
    assign top_idx  = (head == '0) ? PTR_LAST : head - PTR_W'(1);
    assign head_inc = (head == PTR_LAST) ? '0 : head + PTR_W'(1);

    assign ret_addr = bus.pc + ADDR_W'(INSTR_BYTES);

    assign pop     = is_ret && !empty_w;
    assign ovf_evt = is_call && full_w;
    assign unf_evt = is_ret && empty_w;

`ifdef LEG_RSTACK_CIRCULAR_EN
    // When full, head also addresses the oldest entry, so a plain push overwrites it.
    assign push = is_call;
`else
    assign push = is_call && !full_w;
`endif

    assign bus.call           = is_call;
    assign bus.ret            = is_ret;
    assign bus.return_address = is_call ? ret_addr : '0;
    assign bus.redirect       = pop;
    assign bus.ret_target     = pop ? mem[top_idx] : '0;
    assign bus.count          = cnt;
    assign bus.full           = full_w;
    assign bus.empty          = empty_w;
    assign bus.overflow       = ovf_q;
    assign bus.underflow      = unf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head <= '0;
            cnt  <= '0;
        end else if (push) begin
            mem[head] <= ret_addr;
            head      <= head_inc;
            if (!full_w) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (pop) begin
            head <= top_idx;
            cnt  <= cnt - CNT_W'(1);
        end
    end

    // A new error in the same cycle wins over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_q <= 1'b0;
            end
            if (unf_evt) begin
                unf_q <= 1'b1;
            end else if (bus.err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_leg_call_stack.sv
// Self-checking bench for leg_call_stack: directed scenarios plus randomized traffic
// compared against a queue-based LIFO model.
module tb_leg_call_stack;
    localparam int DEPTH = 8;
    localparam logic [7:0] CALL = 8'h26;
    localparam logic [7:0] RET  = 8'h27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] m_q[$];
    logic       m_ovf;
    logic       m_unf;

    leg_call_stack_if #(.ADDR_W(8), .OPCODE_W(8), .DEPTH(DEPTH)) bus ();

    leg_call_stack #(
        .ADDR_W(8), .OPCODE_W(8), .DEPTH(DEPTH),
        .CALL_OP(CALL), .RET_OP(RET), .INSTR_BYTES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Spec-level behaviour: LIFO of at most DEPTH return addresses.
    task automatic model_update(input logic [7:0] op, input logic [7:0] p,
                                input logic v, input logic ec);
        logic o_new;
        logic u_new;
        o_new = 1'b0;
        u_new = 1'b0;
        if (v && op == CALL) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(8'(p + 8'd4));
            end else begin
`ifdef LEG_RSTACK_CIRCULAR_EN
                void'(m_q.pop_front());
                m_q.push_back(8'(p + 8'd4));
`endif
                o_new = 1'b1;
            end
        end else if (v && op == RET) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else u_new = 1'b1;
        end
        m_ovf = o_new ? 1'b1 : (ec ? 1'b0 : m_ovf);
        m_unf = u_new ? 1'b1 : (ec ? 1'b0 : m_unf);
    endtask

    task automatic apply(input logic [7:0] op, input logic [7:0] p,
                         input logic v, input logic ec);
        bus.opcode  = op;
        bus.pc      = p;
        bus.valid   = v;
        bus.err_clr = ec;
        #2;
    endtask

    task automatic tick();
        model_update(bus.opcode, bus.pc, bus.valid, bus.err_clr);
        @(posedge clk);
        #1;
        bus.valid   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.valid   = 1'b0;
        bus.err_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        apply(RET, 8'h00, 1'b1, 1'b0); tick();
        apply(CALL, 8'h30, 1'b1, 1'b0); tick();
        apply(CALL, 8'h40, 1'b1, 1'b0); tick();
        apply(RET, 8'h50, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL async_rst_count got %0d want 0", bus.count); end
        n_tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL async_rst_empty_full got %b%b want 10", bus.empty, bus.full); end
        n_tests++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags got %b%b want 00", bus.underflow, bus.overflow); end
        n_tests++; if (bus.redirect !== 1'b0 || bus.ret_target !== 8'h00) begin n_fail++; $display("FAIL async_rst_redirect got %b/%h want 0/00", bus.redirect, bus.ret_target); end
        bus.valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_call_ret();
        do_reset();
        apply(CALL, 8'h10, 1'b1, 1'b0);
        n_tests++; if (bus.call !== 1'b1 || bus.return_address !== 8'h14) begin n_fail++; $display("FAIL call_ra got %b/%h want 1/14", bus.call, bus.return_address); end
        tick();
        apply(RET, 8'h40, 1'b1, 1'b0);
        n_tests++; if (bus.redirect !== 1'b1 || bus.ret_target !== 8'h14) begin n_fail++; $display("FAIL ret_target got %b/%h want 1/14", bus.redirect, bus.ret_target); end
        tick();
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ret_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_nested();
        logic [7:0] pcs [3];
        logic [7:0] exp [3];
        pcs = '{8'h00, 8'h20, 8'h50};
        exp = '{8'h54, 8'h24, 8'h04};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(CALL, pcs[i], 1'b1, 1'b0); tick();
        end
        for (int i = 0; i < 3; i++) begin
            apply(RET, 8'hA0, 1'b1, 1'b0);
            n_tests++; if (bus.ret_target !== exp[i]) begin n_fail++; $display("FAIL nested_ret%0d got %h want %h", i, bus.ret_target, exp[i]); end
            tick();
        end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL nested_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_overflow();
        logic [7:0] first;
`ifdef LEG_RSTACK_CIRCULAR_EN
        first = 8'h84;
`else
        first = 8'h74;
`endif
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(CALL, 8'(i * 16), 1'b1, 1'b0);
            if (i == 8) begin
                n_tests++; if (bus.call !== 1'b1 || bus.return_address !== 8'h84) begin n_fail++; $display("FAIL full_call_ra got %b/%h want 1/84", bus.call, bus.return_address); end
            end
            tick();
        end
        n_tests++; if (bus.full !== 1'b1 || bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_full_flag got %b%b want 11", bus.full, bus.overflow); end
        n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", bus.count); end
        for (int i = 0; i < 8; i++) begin
            apply(RET, 8'h00, 1'b1, 1'b0);
            n_tests++; if (bus.ret_target !== 8'(first - 8'(i * 16))) begin n_fail++; $display("FAIL ovf_ret%0d got %h want %h", i, bus.ret_target, 8'(first - 8'(i * 16))); end
            tick();
        end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_underflow();
        do_reset();
        apply(RET, 8'h33, 1'b1, 1'b0);
        n_tests++; if (bus.redirect !== 1'b0 || bus.ret_target !== 8'h00) begin n_fail++; $display("FAIL unf_redirect got %b/%h want 0/00", bus.redirect, bus.ret_target); end
        tick();
        n_tests++; if (bus.underflow !== 1'b1 || bus.count !== 4'd0) begin n_fail++; $display("FAIL unf_flag got %b/%0d want 1/0", bus.underflow, bus.count); end
        apply(RET, 8'h33, 1'b1, 1'b1); tick();
        n_tests++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL unf_priority got %b want 1", bus.underflow); end
        apply(8'h00, 8'h00, 1'b0, 1'b1); tick();
        n_tests++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b want 0", bus.underflow); end
    endtask

    task automatic test_wrap_valid();
        do_reset();
        apply(CALL, 8'hFE, 1'b1, 1'b0);
        n_tests++; if (bus.return_address !== 8'h02) begin n_fail++; $display("FAIL wrap_ra got %h want 02", bus.return_address); end
        tick();
        apply(CALL, 8'h10, 1'b0, 1'b0);
        n_tests++; if (bus.call !== 1'b0 || bus.return_address !== 8'h00) begin n_fail++; $display("FAIL novalid_call got %b/%h want 0/00", bus.call, bus.return_address); end
        tick();
        n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL novalid_count got %0d want 1", bus.count); end
    endtask

    task automatic test_random();
        logic [7:0] op;
        logic [7:0] p;
        logic       v;
        logic       ec;
        logic       e_call;
        logic       e_ret;
        logic       e_red;
        logic [7:0] e_ra;
        logic [7:0] e_tgt;
        int         r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 9);
            // alternate call-heavy and ret-heavy phases so full/empty both get exercised
            if (r < (((i / 60) % 2 == 0) ? 7 : 3)) op = CALL;
            else if (r < 9) op = RET;
            else op = 8'($urandom);
            p  = 8'($urandom);
            v  = ($urandom_range(0, 9) != 0);
            ec = ($urandom_range(0, 9) == 0);
            apply(op, p, v, ec);
            e_call = v && op == CALL;
            e_ret  = v && op == RET;
            e_red  = e_ret && m_q.size() > 0;
            e_ra   = e_call ? 8'(p + 8'd4) : 8'h00;
            e_tgt  = e_red ? m_q[$] : 8'h00;
            n_tests++; if (bus.call !== e_call || bus.ret !== e_ret) begin n_fail++; $display("FAIL rnd_decode cyc %0d got %b%b want %b%b", i, bus.call, bus.ret, e_call, e_ret); end
            n_tests++; if (bus.return_address !== e_ra) begin n_fail++; $display("FAIL rnd_ra cyc %0d got %h want %h", i, bus.return_address, e_ra); end
            n_tests++; if (bus.redirect !== e_red || bus.ret_target !== e_tgt) begin n_fail++; $display("FAIL rnd_target cyc %0d got %b/%h want %b/%h", i, bus.redirect, bus.ret_target, e_red, e_tgt); end
            tick();
            n_tests++; if (bus.count !== 4'(m_q.size())) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, bus.count, m_q.size()); end
            n_tests++; if (bus.full !== (m_q.size() == DEPTH) || bus.empty !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rnd_full_empty cyc %0d got %b%b want %b%b", i, bus.full, bus.empty, m_q.size() == DEPTH, m_q.size() == 0); end
            n_tests++; if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin n_fail++; $display("FAIL rnd_flags cyc %0d got %b%b want %b%b", i, bus.overflow, bus.underflow, m_ovf, m_unf); end
        end
    endtask

    initial begin
        bus.opcode  = 8'h00;
        bus.pc      = 8'h00;
        bus.valid   = 1'b0;
        bus.err_clr = 1'b0;
        model_reset();
        test_reset();
        test_call_ret();
        test_nested();
        test_overflow();
        test_underflow();
        test_wrap_valid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
